// File: rtl/parity_pkg.sv
// Shared parity definitions for the stream encoder and its benches.
// Holds the parity polarity, trailer FSM encoding and a reference reduction.
package parity_pkg;

    localparam logic        PARITY_EVEN      = 1'b0;
    localparam int unsigned PARITY_MAX_WIDTH = 64;

    typedef enum logic {
        PASS            = 1'b0,
        TRAILER_PENDING = 1'b1
    } trailer_state_t;

    // Zero-extend narrower words into value; zeros do not change the parity.
    function automatic logic parity_reduce(input logic [PARITY_MAX_WIDTH-1:0] value);
        return PARITY_EVEN ^ (^value);
    endfunction

endpackage

// File: rtl/parity_encoder.sv
// Combinational even-parity code generator for one data word.
module parity_encoder
    import parity_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  code_c
);

    assign code_c = PARITY_EVEN ^ (^data);

endmodule

// File: rtl/parity_stream_encoder.sv
// Valid/ready parity encoder with a two-entry skid buffer and registered ready.
// Define PARITY_STREAM_ENCODER_TRAILER_EN to append a column-parity trailer per packet.
module parity_stream_encoder
    import parity_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  upstream_valid,
    output logic                  upstream_ready,
    input  logic [DATA_WIDTH-1:0] upstream_data,
    input  logic                  upstream_last,
    output logic                  downstream_valid,
    input  logic                  downstream_ready,
    output logic [DATA_WIDTH-1:0] downstream_data,
    output logic                  downstream_code,
    output logic                  downstream_last,
    output logic                  downstream_trailer
);

    logic                  up_fire;
    logic                  dn_fire;
    logic                  data_code;

    // Beat presented to the buffer this cycle (upstream word or generated trailer)
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_code;
    logic                  in_last;
    logic                  in_trailer;
    logic                  block_next;

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_code;
    logic                  skid_last;
    logic                  skid_trailer;

    logic                  out_valid_next;
    logic [DATA_WIDTH-1:0] out_data_next;
    logic                  out_code_next;
    logic                  out_last_next;
    logic                  out_trailer_next;
    logic                  skid_valid_next;
    logic [DATA_WIDTH-1:0] skid_data_next;
    logic                  skid_code_next;
    logic                  skid_last_next;
    logic                  skid_trailer_next;

    assign up_fire = upstream_valid & upstream_ready;
    assign dn_fire = downstream_valid & downstream_ready;

    parity_encoder #(.DATA_WIDTH(DATA_WIDTH)) u_data_enc (
        .data   (upstream_data),
        .code_c (data_code)
    );

`ifdef PARITY_STREAM_ENCODER_TRAILER_EN
    trailer_state_t        state;
    trailer_state_t        state_next;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;
    logic                  acc_code;
    logic                  trailer_queued;
    logic                  trailer_queued_next;

    parity_encoder #(.DATA_WIDTH(DATA_WIDTH)) u_trailer_enc (
        .data   (acc),
        .code_c (acc_code)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= PASS;
            acc            <= '0;
            trailer_queued <= 1'b0;
        end else begin
            state          <= state_next;
            acc            <= acc_next;
            trailer_queued <= trailer_queued_next;
        end
    end

    // The trailer enters the buffer once the skid slot is free, so it queues behind buffered beats.
    always_comb begin
        state_next          = state;
        acc_next            = acc;
        trailer_queued_next = trailer_queued;
        in_valid            = up_fire;
        in_data             = upstream_data;
        in_code             = data_code;
        in_last             = 1'b0;
        in_trailer          = 1'b0;
        case (state)
            PASS: begin
                if (up_fire) begin
                    acc_next = acc ^ upstream_data;
                    if (upstream_last) begin
                        state_next = TRAILER_PENDING;
                    end
                end
            end
            TRAILER_PENDING: begin
                if (!trailer_queued && !skid_valid) begin
                    in_valid            = 1'b1;
                    in_data             = acc;
                    in_code             = acc_code;
                    in_last             = 1'b1;
                    in_trailer          = 1'b1;
                    trailer_queued_next = 1'b1;
                end
                if (dn_fire && downstream_trailer) begin
                    state_next          = PASS;
                    acc_next            = '0;
                    trailer_queued_next = 1'b0;
                end
            end
            default: begin
                state_next = PASS;
            end
        endcase
    end

    assign block_next = (state_next != PASS);
`else
    always_comb begin
        in_valid   = up_fire;
        in_data    = upstream_data;
        in_code    = data_code;
        in_last    = upstream_last;
        in_trailer = 1'b0;
    end

    assign block_next = 1'b0;
`endif

    // Skid buffer: output register refills from skid first, then from the incoming beat.
    always_comb begin
        out_valid_next    = downstream_valid;
        out_data_next     = downstream_data;
        out_code_next     = downstream_code;
        out_last_next     = downstream_last;
        out_trailer_next  = downstream_trailer;
        skid_valid_next   = skid_valid;
        skid_data_next    = skid_data;
        skid_code_next    = skid_code;
        skid_last_next    = skid_last;
        skid_trailer_next = skid_trailer;
        if (!downstream_valid || downstream_ready) begin
            if (skid_valid) begin
                out_valid_next   = 1'b1;
                out_data_next    = skid_data;
                out_code_next    = skid_code;
                out_last_next    = skid_last;
                out_trailer_next = skid_trailer;
                skid_valid_next  = 1'b0;
            end else begin
                out_valid_next = in_valid;
                if (in_valid) begin
                    out_data_next    = in_data;
                    out_code_next    = in_code;
                    out_last_next    = in_last;
                    out_trailer_next = in_trailer;
                end
            end
        end else if (in_valid) begin
            skid_valid_next   = 1'b1;
            skid_data_next    = in_data;
            skid_code_next    = in_code;
            skid_last_next    = in_last;
            skid_trailer_next = in_trailer;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            downstream_valid   <= 1'b0;
            downstream_data    <= '0;
            downstream_code    <= 1'b0;
            downstream_last    <= 1'b0;
            downstream_trailer <= 1'b0;
            skid_valid         <= 1'b0;
            skid_data          <= '0;
            skid_code          <= 1'b0;
            skid_last          <= 1'b0;
            skid_trailer       <= 1'b0;
            upstream_ready     <= 1'b1;
        end else begin
            downstream_valid   <= out_valid_next;
            downstream_data    <= out_data_next;
            downstream_code    <= out_code_next;
            downstream_last    <= out_last_next;
            downstream_trailer <= out_trailer_next;
            skid_valid         <= skid_valid_next;
            skid_data          <= skid_data_next;
            skid_code          <= skid_code_next;
            skid_last          <= skid_last_next;
            skid_trailer       <= skid_trailer_next;
            upstream_ready     <= !skid_valid_next && !block_next;
        end
    end

endmodule

// File: tb/tb_parity_stream_encoder.sv
// Directed bench for parity_stream_encoder with a scoreboard of expected beats.
// Expectations follow PARITY_STREAM_ENCODER_TRAILER_EN when it is defined.
`timescale 1ns/1ps
module tb_parity_stream_encoder;

    localparam int unsigned DATA_WIDTH = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       code;
        logic       last;
        logic       trailer;
    } beat_t;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  upstream_valid;
    logic                  upstream_ready;
    logic [DATA_WIDTH-1:0] upstream_data;
    logic                  upstream_last;
    logic                  downstream_valid;
    logic                  downstream_ready;
    logic [DATA_WIDTH-1:0] downstream_data;
    logic                  downstream_code;
    logic                  downstream_last;
    logic                  downstream_trailer;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    beat_t       expq[$];
    int unsigned dn_cycles[$];
    beat_t       last_pop;
    logic [7:0]  model_acc    = '0;
    logic        trailer_wait = 1'b0;

    parity_stream_encoder #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clock              (clock),
        .reset              (reset),
        .upstream_valid     (upstream_valid),
        .upstream_ready     (upstream_ready),
        .upstream_data      (upstream_data),
        .upstream_last      (upstream_last),
        .downstream_valid   (downstream_valid),
        .downstream_ready   (downstream_ready),
        .downstream_data    (downstream_data),
        .downstream_code    (downstream_code),
        .downstream_last    (downstream_last),
        .downstream_trailer (downstream_trailer)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic par8(input logic [7:0] v);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) p = p ^ v[i];
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_expected(input logic [7:0] d, input logic l);
        beat_t b;
        b.data    = d;
        b.code    = par8(d);
        b.trailer = 1'b0;
`ifdef PARITY_STREAM_ENCODER_TRAILER_EN
        model_acc = model_acc ^ d;
        b.last    = 1'b0;
        expq.push_back(b);
        if (l) begin
            b.data    = model_acc;
            b.code    = par8(model_acc);
            b.last    = 1'b1;
            b.trailer = 1'b1;
            expq.push_back(b);
            model_acc = '0;
        end
`else
        b.last = l;
        expq.push_back(b);
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 after the acceptance edge.
    task automatic send_beat(input logic [7:0] d, input logic l, output int unsigned acc_cyc);
        logic ok;
        ok      = 1'b0;
        acc_cyc = 0;
        upstream_valid = 1'b1;
        upstream_data  = d;
        upstream_last  = l;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clock);
            ok = upstream_ready;
        end
        check("send_accept", 32'(ok), 32'd1);
        if (!ok) begin
            upstream_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        push_expected(d, l);
        @(posedge clock);
        #1;
        upstream_valid = 1'b0;
`ifdef PARITY_STREAM_ENCODER_TRAILER_EN
        if (l) trailer_wait = 1'b1;
`endif
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clock);
            done = (expq.size() == 0);
        end
        check("drain_done", 32'(done), 32'd1);
        repeat (3) @(posedge clock);
        #1;
    endtask

    // Scoreboard consumer: every downstream transfer is popped and compared.
    always @(negedge clock) begin
        if (!reset) begin
            if (trailer_wait) check("ready_blocked", 32'(upstream_ready), 32'd0);
            if (downstream_valid && downstream_ready) begin
                beat_t obs;
                obs.data    = downstream_data;
                obs.code    = downstream_code;
                obs.last    = downstream_last;
                obs.trailer = downstream_trailer;
                dn_cycles.push_back(cyc);
                check("scoreboard_nonempty", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    check("beat", 32'(obs), 32'(expq.pop_front()));
                    last_pop = obs;
                end
                if (downstream_trailer) trailer_wait = 1'b0;
            end
        end
    end

    initial begin
        int unsigned c0;
        int unsigned tmp;
        reset            = 1'b1;
        upstream_valid   = 1'b0;
        upstream_data    = '0;
        upstream_last    = 1'b0;
        downstream_ready = 1'b1;
        #3;
        check("rst_valid",   32'(downstream_valid),   32'd0);
        check("rst_data",    32'(downstream_data),    32'd0);
        check("rst_code",    32'(downstream_code),    32'd0);
        check("rst_last",    32'(downstream_last),    32'd0);
        check("rst_trailer", 32'(downstream_trailer), 32'd0);
        check("rst_ready",   32'(upstream_ready),     32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Two beats with one-cycle latency and known codes
        send_beat(8'hA5, 1'b0, tmp);
        @(negedge clock);
        check("lat_valid_a5", 32'(downstream_valid), 32'd1);
        check("lat_data_a5",  32'(downstream_data),  32'hA5);
        check("lat_code_a5",  32'(downstream_code),  32'd0);
        @(posedge clock);
        #1;
        send_beat(8'h07, 1'b1, tmp);
        @(negedge clock);
        check("lat_data_07", 32'(downstream_data), 32'h07);
        check("lat_code_07", 32'(downstream_code), 32'd1);
        @(posedge clock);
        #1;
        drain();

        // Full-throughput burst
        dn_cycles.delete();
        send_beat(8'h00, 1'b0, c0);
        for (int i = 1; i < 16; i++) send_beat(8'(i), 1'(i == 15), tmp);
        check("burst_up_span", tmp - c0, 32'd15);
        drain();
        check("burst_count_ge16", 32'(dn_cycles.size() >= 16), 32'd1);
        if (dn_cycles.size() >= 16) begin
            check("burst_first_latency", dn_cycles[0] - c0, 32'd1);
            check("burst_dn_span", dn_cycles[15] - dn_cycles[0], 32'd15);
        end

        // Backpressure: third beat is held off until the stall releases
        downstream_ready = 1'b0;
        send_beat(8'h11, 1'b0, tmp);
        send_beat(8'h22, 1'b0, tmp);
        upstream_valid = 1'b1;
        upstream_data  = 8'h33;
        upstream_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_ready_low",    32'(upstream_ready),   32'd0);
            check("bp_valid_held",   32'(downstream_valid), 32'd1);
            check("bp_data_stable",  32'(downstream_data),  32'h11);
        end
        @(posedge clock);
        #1;
        downstream_ready = 1'b1;
        send_beat(8'h33, 1'b1, tmp);
        drain();

        // Packet 01, 02, 04(last)
        dn_cycles.delete();
        send_beat(8'h01, 1'b0, tmp);
        send_beat(8'h02, 1'b0, tmp);
        send_beat(8'h04, 1'b1, tmp);
        drain();
`ifdef PARITY_STREAM_ENCODER_TRAILER_EN
        check("pkt_beats",        32'(dn_cycles.size()), 32'd4);
        check("pkt_trailer_data", 32'(last_pop.data),    32'h07);
        check("pkt_trailer_code", 32'(last_pop.code),    32'd1);
        check("pkt_trailer_flag", 32'(last_pop.trailer), 32'd1);
        check("pkt_trailer_last", 32'(last_pop.last),    32'd1);
`else
        check("pkt_beats",        32'(dn_cycles.size()), 32'd3);
        check("pkt_last_data",    32'(last_pop.data),    32'h04);
        check("pkt_last_flag",    32'(last_pop.last),    32'd1);
        check("pkt_trailer_flag", 32'(last_pop.trailer), 32'd0);
`endif

        // Reset with output and skid both occupied
        downstream_ready = 1'b0;
        send_beat(8'h55, 1'b0, tmp);
        send_beat(8'h66, 1'b0, tmp);
        check("mid_skid_full", 32'(upstream_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(downstream_valid), 32'd0);
        check("mid_rst_ready", 32'(upstream_ready),   32'd1);
        expq.delete();
        model_acc    = '0;
        trailer_wait = 1'b0;
        @(posedge clock);
        #1;
        reset            = 1'b0;
        downstream_ready = 1'b1;
        @(negedge clock);
        check("post_rst_ready", 32'(upstream_ready),   32'd1);
        check("post_rst_valid", 32'(downstream_valid), 32'd0);
        @(posedge clock);
        #1;
        send_beat(8'h80, 1'b1, tmp);
        drain();
        check("post_rst_data", 32'(last_pop.data), 32'h80);
        check("post_rst_code", 32'(last_pop.code), 32'd1);
`ifdef PARITY_STREAM_ENCODER_TRAILER_EN
        check("post_rst_trailer", 32'(last_pop.trailer), 32'd1);
`else
        check("post_rst_trailer", 32'(last_pop.trailer), 32'd0);
`endif
        check("final_queue_empty", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
